// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst types, response codes and write-channel FSM states.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } axi_wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR bursts; INCR wraps silently at the top of the address space.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;

    assign step      = ADDR_WIDTH'(1) << size;
    assign next_addr = (burst == BURST_FIXED) ? cur_addr : cur_addr + step;

endmodule

// File: rtl/axi_slave_write_channel.sv
// AXI write-channel slave: one burst at a time (AW, W beats, B), each accepted beat pushed to the sink.
module axi_slave_write_channel
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH          = 32,
    parameter int WRITE_CHANNEL_WIDTH = 32,
    parameter int WRITE_BURST_LEN     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [WRITE_BURST_LEN-1:0]     AWLEN,
    input  logic [2:0]                     AWSIZE,
    input  logic [1:0]                     AWBURST,
    input  logic                           WVALID,
    output logic                           WREADY,
    input  logic [WRITE_CHANNEL_WIDTH-1:0] WDATA,
    input  logic                           WLAST,
    output logic                           BVALID,
    input  logic                           BREADY,
    output logic [1:0]                     BRESP,
    output logic                           slave2sink_wpush,
    output logic [ADDR_WIDTH-1:0]          slave2sink_waddr,
    output logic [WRITE_CHANNEL_WIDTH-1:0] slave2sink_wdata,
    input  logic                           slave2sink_wfull,
    output logic                           busy
);

    axi_wr_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [WRITE_BURST_LEN-1:0] len_q, len_d;
    logic [2:0]                 size_q, size_d;
    logic [1:0]                 burst_q, burst_d;
    logic [WRITE_BURST_LEN-1:0] cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic                       awready_q, awready_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       busy_q, busy_d;

    logic [ADDR_WIDTH-1:0]      next_addr;
    logic                       w_ready;
    logic                       w_accept;
    logic                       at_len;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .cur_addr  (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Sink backpressure reaches WREADY in the same cycle so no beat is ever dropped.
    assign w_ready  = (state_q == DATA) && !slave2sink_wfull;
    assign w_accept = w_ready && WVALID;
    assign at_len   = (cnt_q == len_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (AWVALID) begin
                    addr_d  = AWADDR;
                    len_d   = AWLEN;
                    size_d  = AWSIZE;
                    burst_d = AWBURST[1] ? BURST_INCR : AWBURST;
                    cnt_d   = '0;
                    err_d   = AWBURST[1];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_accept) begin
                    addr_d = next_addr;
                    cnt_d  = cnt_q + 1'b1;
                    // Early WLAST and missing WLAST both flag the burst.
                    if (WLAST != at_len) begin
                        err_d = 1'b1;
                    end
                    if (WLAST || at_len) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
        bvalid_d  = (state_d == RESP);
        bresp_d   = ((state_d == RESP) && err_d) ? RESP_SLVERR : RESP_OKAY;
        busy_d    = (state_d != IDLE);
    end

    // NOTE: all state uses non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, since a burst interrupted by reset is simply discarded.
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            busy_q    <= busy_d;
        end
    end

    assign AWREADY          = awready_q;
    assign WREADY           = w_ready;
    assign BVALID           = bvalid_q;
    assign BRESP            = bresp_q;
    assign busy             = busy_q;
    assign slave2sink_wpush = w_accept;
    assign slave2sink_waddr = addr_q;
    assign slave2sink_wdata = WDATA;

endmodule

// File: doc/axi_slave_write_channel.md
Name: axi_slave_write_channel

Overview:
AXI write-channel responder, the counterpart of the team's master write channel. Accepts one write burst at a time:
- AW handshake, then W beats, then B response.
- Each accepted W beat is pushed, with its computed beat address, into a slave-side write FIFO/memory port.
- Sits between the AXI interconnect and the slave-side buffer that feeds the DMA or memory model.

Parameters:
ADDR_WIDTH, 32, width of AWADDR and of the beat address to the sink
WRITE_CHANNEL_WIDTH, 32, WDATA width in bits
WRITE_BURST_LEN, 8, width of AWLEN and of the beat counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
AWADDR  input  ADDR_WIDTH  burst start address
AWLEN  input  WRITE_BURST_LEN  beats minus one
AWSIZE  input  3  bytes per beat = 1<<AWSIZE
AWBURST  input  2  00 FIXED, 01 INCR, 1x unsupported
WVALID  input  1  write data valid
WREADY  output  1  write data ready
WDATA  input  WRITE_CHANNEL_WIDTH  beat data
WLAST  input  1  last beat marker
BVALID  output  1  write response valid
BREADY  input  1  write response ready
BRESP  output  2  00 OKAY, 10 SLVERR
slave2sink_wpush  output  1  push strobe to sink, one per accepted beat
slave2sink_waddr  output  ADDR_WIDTH  address of the pushed beat
slave2sink_wdata  output  WRITE_CHANNEL_WIDTH  data of the pushed beat
slave2sink_wfull  input  1  sink cannot accept a push this cycle
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE.
  - All registers are cleared: addr, len, size, burst, beat counter, error flag.
  - Outputs after reset: AWREADY=1, WREADY=0, BVALID=0, BRESP=00, wpush=0, busy=0.
  - Reset mid-burst abandons the burst. No B response is issued for it.
- States: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1.
  - On AWVALID: latch AWADDR, AWLEN, AWSIZE and AWBURST; clear cnt and err; go to DATA next cycle.
  - If AWBURST[1]=1: set err=1 and treat the burst as INCR.
  - W signals are ignored in IDLE (WREADY=0).
- DATA:
  - WREADY = !slave2sink_wfull, combinational. AWREADY=0.
  - A beat is accepted when WVALID && WREADY.
  - On an accepted beat:
    - wpush=1 in the same cycle.
    - wdata=WDATA.
    - waddr=cur_addr.
  - After each accepted beat:
    - INCR: cur_addr += (1<<size), truncated to ADDR_WIDTH; wrap-around at the top of the address space is silent.
    - FIXED: cur_addr is unchanged.
    - cnt += 1.
  - The burst ends on an accepted beat where WLAST=1 or cnt==len, whichever comes first. Then go to RESP.
  - WLAST mismatch sets err=1:
    - WLAST=1 with cnt<len (early), or
    - WLAST=0 with cnt==len (missing).
  - An early WLAST terminates the burst. No further beats are accepted.
  - wfull held high stalls indefinitely. No timeout.
- RESP:
  - BVALID=1. BRESP = err ? 10 : 00. WREADY=0, AWREADY=0.
  - On BREADY: go to IDLE. The next AW can be accepted one cycle later, since AWREADY rises only in IDLE.
  - BVALID stays high and BRESP stays stable until BREADY.
- Latency:
  - AW handshake to first possible WREADY: 1 cycle.
  - Last W beat to BVALID: 1 cycle.
  - Minimum burst of N beats: N+2 cycles plus the B handshake.
- Simultaneous events:
  - AW and W valid in the same IDLE cycle: only AW is taken; the W beat is taken next cycle.
  - W presented while in RESP is not accepted.
- Sink path: wpush is combinational from WVALID&&WREADY. The sink samples it at the same edge.

Decomposition:
- Shared package axi_pkg holds:
  - burst type constants: BURST_FIXED=2'b00, BURST_INCR=2'b01
  - response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - state encodings: IDLE, DATA, RESP
- One natural sub-module: axi_burst_addr_gen. It computes the next beat address from cur_addr, size and burst type, and is reusable by a future read-channel slave.

Test Plan:
- INCR burst: AWADDR=0x100, AWLEN=3, AWSIZE=2, AWBURST=01, 4 beats with WLAST on beat 4 → pushes at 0x100, 0x104, 0x108, 0x10C; BVALID one cycle later with BRESP=00.
- FIXED burst: AWADDR=0x40, AWLEN=2, AWBURST=00 → 3 pushes all at waddr=0x40; BRESP=00.
- Backpressure: wfull high for 5 cycles mid-burst → WREADY=0 and no wpush during the stall; the burst completes with correct addresses once wfull drops.
- Early WLAST: AWLEN=3, WLAST on beat 2 → 2 pushes, then RESP with BRESP=10. Missing WLAST on beat 4 also gives BRESP=10.
- B stall: BREADY low 4 cycles → BVALID/BRESP held stable and AWREADY=0. After BREADY, AWREADY=1 the next cycle.
- Reset mid-DATA after 1 of 4 beats → next cycle AWREADY=1, WREADY=0, BVALID=0; a new burst then completes normally. AWBURST=2'b10 burst also completes, as INCR with BRESP=10.
